mem_arbiter: RTL and testbench

- Single-port memory arbiter directly downstream of the request unit.
- Consumes the instruction fetch request (iREN) and the request unit's data requests (dmemREN/dmemWEN), and serialises them onto one RAM port.
- Produces the ihit/dhit strobes that the request unit and datapath consume.
- Data has priority, with one-shot fairness so that fetch cannot be starved. Includes a stuck-access watchdog.

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/arb_watchdog.sv | 28 ++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, the word type and the memory arbiter's grant states.
package cpu_types_pkg;

    localparam int WORD_BITS = 32;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of request-unit, RAM and status signals around the memory arbiter.
interface mem_arbiter_if #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic              ihit;
    logic              dhit;
    logic [WORD_W-1:0] iload;
    logic [WORD_W-1:0] dload;
    logic              mem_err;
    logic [CNT_W-1:0]  icount;
    logic [CNT_W-1:0]  dcount;

    modport arb (
        input  iREN, iaddr, dmemREN, dmemWEN, daddr, dstore, ramload, ramstate,
        output ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload,
               mem_err, icount, dcount
    );

    modport tb (
        output iREN, iaddr, dmemREN, dmemWEN, daddr, dstore, ramload, ramstate,
        input  ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload,
               mem_err, icount, dcount
    );

endinterface

// File: rtl/arb_watchdog.sv
// Grant-age counter: cleared while idle, saturates at TIMEOUT-1 and flags expiry there.
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] wdog;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= '0;
        end else if (clear) begin
            wdog <= '0;
        end else if (wdog != LIMIT) begin
            wdog <= wdog + CW'(1);
        end
    end

    assign expire = (wdog == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction fetch and data requests onto a single RAM port; data wins ties
// unless the previous grant was data, and a watchdog aborts grants that never see ACCESS.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    output logic              ihit,
    output logic              dhit,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              mem_err,
    output logic [CNT_W-1:0]  icount,
    output logic [CNT_W-1:0]  dcount
);

    arb_state_t state;
    ramstate_t  rs;
    logic       last_d;
    logic       dreq;
    logic       owner_req;
    logic       access;
    logic       expire;
    logic       wd_clear;

    assign rs   = ramstate_t'(ramstate);
    assign dreq = dmemREN | dmemWEN;

    // RAM port follows the current owner combinationally; nothing is latched.
    always_comb begin
        owner_req = 1'b0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        unique case (state)
            DACC: begin
                owner_req = dreq;
                ramaddr   = daddr;
                ramstore  = dstore;
                ramWEN    = dmemWEN;
                ramREN    = dmemREN & ~dmemWEN;
            end
            IACC: begin
                owner_req = iREN;
                ramaddr   = iaddr;
                ramREN    = iREN;
            end
            default: ;
        endcase
    end

    assign access = owner_req && (rs == ACCESS);
    assign dhit   = access && (state == DACC);
    assign ihit   = access && (state == IACC);
    assign dload  = dhit ? ramload : '0;
    assign iload  = ihit ? ramload : '0;

    assign wd_clear = (state == IDLE);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (CLK),
        .rst_n  (nRST),
        .clear  (wd_clear),
        .expire (expire)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            mem_err <= 1'b0;
            icount  <= '0;
            dcount  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dreq && !(iREN && last_d)) begin
                        state <= DACC;
                    end else if (iREN) begin
                        state <= IACC;
                    end
                end
                DACC, IACC: begin
                    if (!owner_req) begin
                        // Withdrawn request (flush): drop the grant silently.
                        state <= IDLE;
                    end else if (access) begin
                        state  <= IDLE;
                        last_d <= (state == DACC);
                        if (state == DACC) begin
                            if (dcount != '1) dcount <= dcount + CNT_W'(1);
                        end else begin
                            if (icount != '1) icount <= icount + CNT_W'(1);
                        end
                    end else if (rs == ERROR || expire) begin
                        mem_err <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner-case sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int WORD_W  = 32;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 8;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    localparam logic [31:0] DADDR  = 32'h0000_0100;
    localparam logic [31:0] IADDR  = 32'h0000_0400;
    localparam logic [31:0] DSTORE = 32'hCAFE_0000;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    mem_arbiter_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .WORD_W  (WORD_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (bus.iREN),
        .iaddr    (bus.iaddr),
        .dmemREN  (bus.dmemREN),
        .dmemWEN  (bus.dmemWEN),
        .daddr    (bus.daddr),
        .dstore   (bus.dstore),
        .ramload  (bus.ramload),
        .ramstate (bus.ramstate),
        .ramREN   (bus.ramREN),
        .ramWEN   (bus.ramWEN),
        .ramaddr  (bus.ramaddr),
        .ramstore (bus.ramstore),
        .ihit     (bus.ihit),
        .dhit     (bus.dhit),
        .iload    (bus.iload),
        .dload    (bus.dload),
        .mem_err  (bus.mem_err),
        .icount   (bus.icount),
        .dcount   (bus.dcount)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rst;
        logic        iren;
        logic        dren;
        logic        dwen;
        logic [1:0]  rs;
        logic [31:0] load;
        logic        e_ren;
        logic        e_wen;
        logic        e_ih;
        logic        e_dh;
        logic [31:0] e_addr;
        int          e_ic;
        int          e_dc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit rst, logic iren, logic dren, logic dwen, logic [1:0] rs,
                               logic [31:0] load, logic e_ren, logic e_wen, logic e_ih,
                               logic e_dh, logic [31:0] e_addr, int e_ic, int e_dc);
        vec_t r;
        r.rst = rst; r.iren = iren; r.dren = dren; r.dwen = dwen; r.rs = rs; r.load = load;
        r.e_ren = e_ren; r.e_wen = e_wen; r.e_ih = e_ih; r.e_dh = e_dh; r.e_addr = e_addr;
        r.e_ic = e_ic; r.e_dc = e_dc;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iren, input logic dren, input logic dwen,
                         input logic [1:0] rs, input logic [31:0] load);
        bus.iREN     = iren;
        bus.dmemREN  = dren;
        bus.dmemWEN  = dwen;
        bus.ramstate = rs;
        bus.ramload  = load;
        bus.iaddr    = IADDR;
        bus.daddr    = DADDR;
        bus.dstore   = DSTORE;
    endtask

    // Leaves the bench just after a falling edge with reset released.
    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, RS_FREE, 32'h0);
        nRST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Reference model state, transaction level.
    int owner;          // 0 none, 1 data, 2 instruction
    int waited;
    bit prefer_instr;
    bit m_err;
    int m_ic;
    int m_dc;

    task automatic model_reset();
        owner = 0; waited = 0; prefer_instr = 1'b0; m_err = 1'b0; m_ic = 0; m_dc = 0;
    endtask

    initial begin
        logic        exp_ren, exp_wen, exp_ih, exp_dh, dreq, oreq;
        logic [31:0] exp_addr, exp_store;
        int          r;
        int          sat;

        sat = (1 << CNT_W) - 1;
        do_reset();

        // Reset state
        #1;
        check("rst.ramREN", 32'(bus.ramREN), 32'd0);
        check("rst.ramWEN", 32'(bus.ramWEN), 32'd0);
        check("rst.ihit", 32'(bus.ihit), 32'd0);
        check("rst.dhit", 32'(bus.dhit), 32'd0);
        check("rst.mem_err", 32'(bus.mem_err), 32'd0);
        check("rst.icount", 32'(bus.icount), 32'd0);
        check("rst.dcount", 32'(bus.dcount), 32'd0);
        @(negedge CLK);

        // Single read, then D/I alternation with both held, then write-beats-read.
        vecs.push_back(v(1, 0, 1, 0, RS_ACCESS, 32'hDEADBEEF, 0, 0, 0, 0, 0,     0, 0));
        vecs.push_back(v(0, 0, 1, 0, RS_ACCESS, 32'hDEADBEEF, 1, 0, 0, 1, DADDR, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, RS_ACCESS, 32'hDEADBEEF, 0, 0, 0, 0, 0,     0, 1));
        vecs.push_back(v(1, 1, 0, 1, RS_ACCESS, 32'h11111111, 0, 0, 0, 0, 0,     0, 0));
        vecs.push_back(v(0, 1, 0, 1, RS_ACCESS, 32'h22222222, 0, 1, 0, 1, DADDR, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, RS_ACCESS, 32'h33333333, 0, 0, 0, 0, 0,     0, 1));
        vecs.push_back(v(0, 1, 0, 1, RS_ACCESS, 32'h44444444, 1, 0, 1, 0, IADDR, 0, 1));
        vecs.push_back(v(0, 1, 0, 1, RS_ACCESS, 32'h55555555, 0, 0, 0, 0, 0,     1, 1));
        vecs.push_back(v(0, 1, 0, 1, RS_ACCESS, 32'h66666666, 0, 1, 0, 1, DADDR, 1, 1));
        vecs.push_back(v(0, 1, 0, 1, RS_ACCESS, 32'h77777777, 0, 0, 0, 0, 0,     1, 2));
        vecs.push_back(v(0, 1, 0, 1, RS_ACCESS, 32'h88888888, 1, 0, 1, 0, IADDR, 1, 2));
        vecs.push_back(v(0, 0, 0, 0, RS_FREE,   32'h0,        0, 0, 0, 0, 0,     2, 2));
        vecs.push_back(v(0, 0, 1, 1, RS_ACCESS, 32'h99999999, 0, 0, 0, 0, 0,     2, 2));
        vecs.push_back(v(0, 0, 1, 1, RS_ACCESS, 32'hAAAAAAAA, 0, 1, 0, 1, DADDR, 2, 2));
        vecs.push_back(v(0, 0, 0, 0, RS_FREE,   32'h0,        0, 0, 0, 0, 0,     2, 3));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].iren, vecs[i].dren, vecs[i].dwen, vecs[i].rs, vecs[i].load);
            #1;
            check($sformatf("vec%0d.ramREN", i), 32'(bus.ramREN), 32'(vecs[i].e_ren));
            check($sformatf("vec%0d.ramWEN", i), 32'(bus.ramWEN), 32'(vecs[i].e_wen));
            check($sformatf("vec%0d.ihit", i), 32'(bus.ihit), 32'(vecs[i].e_ih));
            check($sformatf("vec%0d.dhit", i), 32'(bus.dhit), 32'(vecs[i].e_dh));
            check($sformatf("vec%0d.ramaddr", i), bus.ramaddr, vecs[i].e_addr);
            check($sformatf("vec%0d.iload", i), bus.iload, vecs[i].e_ih ? vecs[i].load : 32'h0);
            check($sformatf("vec%0d.dload", i), bus.dload, vecs[i].e_dh ? vecs[i].load : 32'h0);
            check($sformatf("vec%0d.icount", i), 32'(bus.icount), 32'(vecs[i].e_ic));
            check($sformatf("vec%0d.dcount", i), 32'(bus.dcount), 32'(vecs[i].e_dc));
            @(negedge CLK);
        end

        // Fetch with five BUSY cycles in the grant, then ACCESS: hit only in cycle 7.
        do_reset();
        for (int c = 1; c <= 7; c++) begin
            drive(1'b1, 1'b0, 1'b0, (c == 7) ? RS_ACCESS : RS_BUSY, 32'h8C220004);
            #1;
            check($sformatf("busy.c%0d.ihit", c), 32'(bus.ihit), 32'(c == 7));
            check($sformatf("busy.c%0d.ramREN", c), 32'(bus.ramREN), 32'(c >= 2));
            check($sformatf("busy.c%0d.ramaddr", c), bus.ramaddr, (c >= 2) ? IADDR : 32'h0);
            check($sformatf("busy.c%0d.iload", c), bus.iload, (c == 7) ? 32'h8C220004 : 32'h0);
            @(negedge CLK);
        end
        drive(1'b0, 1'b0, 1'b0, RS_FREE, 32'h0);
        #1;
        check("busy.icount", 32'(bus.icount), 32'd1);
        @(negedge CLK);

        // Stuck BUSY: grant aborted after TIMEOUT cycles, error sticks, next fetch served.
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            drive(1'b1, 1'b0, 1'b0, RS_BUSY, 32'h12345678);
            #1;
            check($sformatf("tmo.c%0d.ihit", c), 32'(bus.ihit), 32'd0);
            check($sformatf("tmo.c%0d.ramREN", c), 32'(bus.ramREN), 32'(c >= 2 && c <= TIMEOUT + 1));
            check($sformatf("tmo.c%0d.mem_err", c), 32'(bus.mem_err), 32'(c >= TIMEOUT + 2));
            @(negedge CLK);
        end
        drive(1'b1, 1'b0, 1'b0, RS_ACCESS, 32'h0BADF00D);
        #1;
        check("tmo.retry.ihit", 32'(bus.ihit), 32'd1);
        check("tmo.retry.iload", bus.iload, 32'h0BADF00D);
        check("tmo.retry.mem_err", 32'(bus.mem_err), 32'd1);
        @(negedge CLK);

        // Async reset in the middle of a data write grant.
        drive(1'b0, 1'b0, 1'b1, RS_BUSY, 32'h0);
        #1;
        check("arst.pre.icount", 32'(bus.icount), 32'd1);
        check("arst.pre.mem_err", 32'(bus.mem_err), 32'd1);
        @(negedge CLK);
        #1;
        check("arst.grant.ramWEN", 32'(bus.ramWEN), 32'd1);
        nRST = 1'b0;
        #1;
        check("arst.ramWEN", 32'(bus.ramWEN), 32'd0);
        check("arst.ramREN", 32'(bus.ramREN), 32'd0);
        check("arst.ramaddr", bus.ramaddr, 32'h0);
        check("arst.mem_err", 32'(bus.mem_err), 32'd0);
        check("arst.icount", 32'(bus.icount), 32'd0);
        check("arst.dcount", 32'(bus.dcount), 32'd0);
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b0, RS_FREE, 32'h0);
        nRST = 1'b1;

        // Data read withdrawn while BUSY: no hit even if ACCESS arrives with the request low.
        do_reset();
        for (int c = 1; c <= 7; c++) begin
            drive((1'b0), (c != 4 && c != 7), 1'b0, (c >= 4) ? RS_ACCESS : RS_BUSY, 32'h5A5A5A5A);
            #1;
            check($sformatf("wd.c%0d.dhit", c), 32'(bus.dhit), 32'(c == 6));
            check($sformatf("wd.c%0d.ramREN", c), 32'(bus.ramREN), 32'(c == 2 || c == 3 || c == 6));
            check($sformatf("wd.c%0d.dcount", c), 32'(bus.dcount), 32'(c == 7));
            @(negedge CLK);
        end

        // ERROR response: sticky error, no hit, back to IDLE.
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            drive(1'b0, (c <= 3), 1'b0, (c == 2) ? RS_ERROR : RS_BUSY, 32'h77777777);
            #1;
            check($sformatf("err.c%0d.dhit", c), 32'(bus.dhit), 32'd0);
            check($sformatf("err.c%0d.mem_err", c), 32'(bus.mem_err), 32'(c >= 3));
            check($sformatf("err.c%0d.ramREN", c), 32'(bus.ramREN), 32'(c == 2));
            check($sformatf("err.c%0d.dcount", c), 32'(bus.dcount), 32'd0);
            @(negedge CLK);
        end

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        drive(1'b0, 1'b0, 1'b0, RS_FREE, 32'h0);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) bus.iREN = ~bus.iREN;
            if ($urandom_range(0, 7) == 0) bus.dmemREN = ~bus.dmemREN;
            if ($urandom_range(0, 15) == 0) bus.dmemWEN = ~bus.dmemWEN;
            bus.iaddr   = $urandom;
            bus.daddr   = $urandom;
            bus.dstore  = $urandom;
            bus.ramload = $urandom;
            r = $urandom_range(0, 15);
            bus.ramstate = (r < 5) ? RS_ACCESS : (r == 5) ? RS_ERROR : (r < 11) ? RS_BUSY : RS_FREE;
            #1;

            dreq = bus.dmemREN | bus.dmemWEN;
            oreq = 1'b0;
            exp_ren = 1'b0; exp_wen = 1'b0; exp_ih = 1'b0; exp_dh = 1'b0;
            exp_addr = 32'h0; exp_store = 32'h0;
            if (owner == 1) begin
                oreq      = dreq;
                exp_addr  = bus.daddr;
                exp_store = bus.dstore;
                exp_wen   = bus.dmemWEN;
                exp_ren   = bus.dmemREN && !bus.dmemWEN;
                exp_dh    = dreq && bus.ramstate == RS_ACCESS;
            end else if (owner == 2) begin
                oreq     = bus.iREN;
                exp_addr = bus.iaddr;
                exp_ren  = bus.iREN;
                exp_ih   = bus.iREN && bus.ramstate == RS_ACCESS;
            end

            check("rnd.ramREN", 32'(bus.ramREN), 32'(exp_ren));
            check("rnd.ramWEN", 32'(bus.ramWEN), 32'(exp_wen));
            check("rnd.ramaddr", bus.ramaddr, exp_addr);
            check("rnd.ramstore", bus.ramstore, exp_store);
            check("rnd.ihit", 32'(bus.ihit), 32'(exp_ih));
            check("rnd.dhit", 32'(bus.dhit), 32'(exp_dh));
            check("rnd.iload", bus.iload, exp_ih ? bus.ramload : 32'h0);
            check("rnd.dload", bus.dload, exp_dh ? bus.ramload : 32'h0);
            check("rnd.mem_err", 32'(bus.mem_err), 32'(m_err));
            check("rnd.icount", 32'(bus.icount), 32'(m_ic));
            check("rnd.dcount", 32'(bus.dcount), 32'(m_dc));

            if (owner == 0) begin
                waited = 0;
                if (dreq && !(bus.iREN && prefer_instr)) owner = 1;
                else if (bus.iREN) owner = 2;
            end else if (!oreq) begin
                owner = 0;
            end else if (bus.ramstate == RS_ACCESS) begin
                if (owner == 1) begin
                    if (m_dc < sat) m_dc++;
                    prefer_instr = 1'b1;
                end else begin
                    if (m_ic < sat) m_ic++;
                    prefer_instr = 1'b0;
                end
                owner = 0;
            end else if (bus.ramstate == RS_ERROR || waited == TIMEOUT - 1) begin
                m_err = 1'b1;
                owner = 0;
            end else begin
                waited++;
            end
            @(negedge CLK);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
